// File: rtl/uart_tx_arbiter.sv
// Round-robin, message-locked arbiter that merges NUM_SRC AXI-stream byte sources into one uart_tx input.
// Optional idle-release watchdog is enabled by defining UART_TX_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
  parameter int NUM_SRC        = 4,
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_SRC*DATA_WIDTH-1:0] s_tdata,
  input  logic [NUM_SRC-1:0]            s_tvalid,
  input  logic [NUM_SRC-1:0]            s_tlast,
  output logic [NUM_SRC-1:0]            s_tready,
  output logic [DATA_WIDTH-1:0]         m_tdata,
  output logic                          m_tvalid,
  input  logic                          m_tready,
  output logic [NUM_SRC-1:0]            grant,
  output logic                          timeout
);

  localparam int PW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t        state;
  logic [PW-1:0] ptr;
  logic [PW-1:0] gidx;
  logic [PW-1:0] pick_idx;
  logic [PW-1:0] next_ptr;
  logic          pick_vld;
  logic          slot_free;
  logic          accept;

  // Scan downward so the lowest offset from ptr is the one left standing.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      if (s_tvalid[(int'(ptr) + k) % NUM_SRC]) begin
        pick_vld = 1'b1;
        pick_idx = PW'((int'(ptr) + k) % NUM_SRC);
      end
    end
  end

  // grant is zero outside LOCKED, so ready and accept need no state qualifier.
  assign slot_free = !m_tvalid || m_tready;
  assign s_tready  = grant & {NUM_SRC{slot_free}};
  assign accept    = |(s_tvalid & s_tready);
  assign next_ptr  = PW'((int'(gidx) + 1) % NUM_SRC);

`ifdef UART_TX_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] idle_cnt;
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= '0;
      gidx     <= '0;
      grant    <= '0;
      m_tdata  <= '0;
      m_tvalid <= 1'b0;
`ifdef UART_TX_ARB_TIMEOUT_EN
      idle_cnt <= '0;
      timeout  <= 1'b0;
`endif
    end else begin
`ifdef UART_TX_ARB_TIMEOUT_EN
      timeout <= 1'b0;
`endif
      if (accept) begin
        m_tdata  <= s_tdata[int'(gidx)*DATA_WIDTH +: DATA_WIDTH];
        m_tvalid <= 1'b1;
      end else if (m_tready) begin
        m_tvalid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (pick_vld) begin
            grant <= NUM_SRC'(1) << pick_idx;
            gidx  <= pick_idx;
            state <= LOCKED;
          end
        end
        LOCKED: begin
          if (accept && s_tlast[gidx]) begin
            grant <= '0;
            state <= IDLE;
            ptr   <= next_ptr;
`ifdef UART_TX_ARB_TIMEOUT_EN
            idle_cnt <= '0;
          end else if (s_tvalid[gidx]) begin
            idle_cnt <= '0;
          end else if (idle_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
            // Source went quiet mid-message: free the stream for the others.
            timeout  <= 1'b1;
            grant    <= '0;
            state    <= IDLE;
            ptr      <= next_ptr;
            idle_cnt <= '0;
          end else begin
            idle_cnt <= idle_cnt + 1'b1;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: per-source byte queues drive the inputs, logs of grant/output are
// compared against hand-derived per-cycle sequences.
module tb_uart_tx_arbiter;
  logic        clk;
  logic        rst;
  logic [31:0] s_tdata;
  logic [3:0]  s_tvalid;
  logic [3:0]  s_tlast;
  logic [3:0]  s_tready;
  logic [7:0]  m_tdata;
  logic        m_tvalid;
  logic        m_tready;
  logic [3:0]  grant;
  logic        timeout;

  int checks = 0;
  int failures = 0;

  logic [8:0] mem [4][16];
  int head [4];
  int tail [4];
  int glog [$];
  int olog [$];
  int tocnt, tocyc, holdviol, stall_rdy;

  uart_tx_arbiter #(.NUM_SRC(4), .DATA_WIDTH(8), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
    .grant(grant), .timeout(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push(input int s, input logic [7:0] d, input logic last);
    mem[s][tail[s]] = {last, d};
    tail[s]++;
  endtask

  task automatic clear_q();
    for (int i = 0; i < 4; i++) begin
      head[i] = 0;
      tail[i] = 0;
    end
  endtask

  task automatic do_reset(input bit check_vals);
    rst = 1'b1;
    s_tvalid = '0;
    s_tlast = '0;
    s_tdata = '0;
    m_tready = 1'b1;
    clear_q();
    repeat (2) @(posedge clk);
    @(negedge clk);
    if (check_vals) begin
      chk("rst_s_tready", 64'(s_tready), 64'h0);
      chk("rst_m_tvalid", 64'(m_tvalid), 64'h0);
      chk("rst_m_tdata", 64'(m_tdata), 64'h0);
      chk("rst_grant", 64'(grant), 64'h0);
      chk("rst_timeout", 64'(timeout), 64'h0);
    end
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Cycle c is entered at posedge+1; m_tready is low for cycles lo_from..lo_to.
  task automatic run(input int n, input int lo_from, input int lo_to);
    bit         pv_stall;
    logic [7:0] pdata;
    logic [3:0] pop;
    pv_stall = 1'b0;
    pdata = '0;
    glog.delete();
    olog.delete();
    tocnt = 0; tocyc = -1; holdviol = 0; stall_rdy = 0;
    for (int c = 0; c < n; c++) begin
      for (int i = 0; i < 4; i++) begin
        s_tvalid[i] = (head[i] != tail[i]);
        s_tdata[i*8 +: 8] = mem[i][head[i]][7:0];
        s_tlast[i] = mem[i][head[i]][8] && (head[i] != tail[i]);
      end
      m_tready = !(c >= lo_from && c <= lo_to);
      @(negedge clk);
      glog.push_back(int'(grant));
      if (m_tvalid && m_tready) olog.push_back(int'(m_tdata));
      if (timeout) begin
        tocnt++;
        tocyc = c;
      end
      if (pv_stall && (!m_tvalid || m_tdata != pdata)) holdviol++;
      if (m_tvalid && !m_tready && s_tready != 0) stall_rdy++;
      pv_stall = m_tvalid && !m_tready;
      pdata = m_tdata;
      pop = s_tvalid & s_tready;
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) if (pop[i]) head[i]++;
    end
    s_tvalid = '0;
    s_tlast = '0;
    m_tready = 1'b1;
  endtask

  // eg: one nibble of grant per cycle, cycle 0 in the top nibble; eo: one byte per output beat.
  task automatic chk_logs(input string tag, input logic [255:0] eg, input int ng,
                          input logic [63:0] eo, input int no);
    chk({tag, "_glen"}, 64'(glog.size()), 64'(ng));
    for (int c = 0; c < ng && c < glog.size(); c++)
      chk($sformatf("%s_grant_c%0d", tag, c), 64'(glog[c]), 64'(eg[(ng-1-c)*4 +: 4]));
    chk({tag, "_olen"}, 64'(olog.size()), 64'(no));
    for (int b = 0; b < no && b < olog.size(); b++)
      chk($sformatf("%s_byte%0d", tag, b), 64'(olog[b]), 64'(eo[(no-1-b)*8 +: 8]));
  endtask

  initial begin
    rst = 1'b1;
    s_tvalid = '0;
    s_tlast = '0;
    s_tdata = '0;
    m_tready = 1'b1;
    clear_q();

    do_reset(1'b1);

    // Single 3-byte message from src0.
    push(0, 8'h41, 1'b0); push(0, 8'h42, 1'b0); push(0, 8'h43, 1'b1);
    run(6, -1, -1);
    chk_logs("t1", 256'h011100, 6, 64'h414243, 3);

    // src0 (2-byte msg + queued re-request) against src2: rr pointer hands src2 the second turn.
    do_reset(1'b0);
    push(0, 8'h20, 1'b0); push(0, 8'h21, 1'b1); push(0, 8'h22, 1'b1);
    push(2, 8'h30, 1'b1);
    run(9, -1, -1);
    chk_logs("t2", 256'h011040100, 9, 64'h20213022, 4);

    // Four sources always valid, 1-byte messages: rotation with a bubble after each release.
    do_reset(1'b0);
    push(0, 8'h10, 1'b1); push(0, 8'h14, 1'b1);
    push(1, 8'h11, 1'b1); push(2, 8'h12, 1'b1); push(3, 8'h13, 1'b1);
    run(11, -1, -1);
    chk_logs("t4", 256'h01020408010, 11, 64'h1011121314, 5);

    // Downstream stall for 10 cycles after src1's first beat.
    do_reset(1'b0);
    push(1, 8'h50, 1'b0); push(1, 8'h51, 1'b1);
    run(14, 2, 11);
    chk_logs("t3", 256'h02222222222220, 14, 64'h5051, 2);
    chk("t3_hold", 64'(holdviol), 64'h0);
    chk("t3_ready_in_stall", 64'(stall_rdy), 64'h0);

    // Reset in the middle of a src3 message (ptr is 2 going in, so src3 wins).
    clear_q();
    push(3, 8'h60, 1'b0); push(3, 8'h61, 1'b0); push(3, 8'h62, 1'b1);
    run(3, -1, -1);
    chk_logs("t5a", 256'h088, 3, 64'h60, 1);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("t5_rst_m_tvalid", 64'(m_tvalid), 64'h0);
    chk("t5_rst_grant", 64'(grant), 64'h0);
    chk("t5_rst_s_tready", 64'(s_tready), 64'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    clear_q();
    push(1, 8'h70, 1'b1);
    push(3, 8'h80, 1'b1);
    run(5, -1, -1);
    chk_logs("t5b", 256'h02080, 5, 64'h7080, 2);

    // src2 sends one byte without tlast, then goes quiet.
    do_reset(1'b0);
    push(2, 8'h90, 1'b0);
    run(40, -1, -1);
`ifdef UART_TX_ARB_TIMEOUT_EN
    chk("t6_grant_end", 64'(glog[39]), 64'h0);
    chk("t6_grant_pre", 64'(glog[17]), 64'h4);
    chk("t6_grant_rel", 64'(glog[18]), 64'h0);
    chk("t6_pulses", 64'(tocnt), 64'h1);
    chk("t6_pulse_cycle", 64'(tocyc), 64'd18);
`else
    chk("t6_grant_end", 64'(glog[39]), 64'h4);
    chk("t6_pulses", 64'(tocnt), 64'h0);
`endif
    chk("t6_byte", 64'(olog.size() > 0 ? olog[0] : -1), 64'h90);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
